// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and constants for the UART word receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int LANE_W = 8;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - line synchroniser, byte framing FSM and bit-period counter
// Optional even parity is compiled in with UART_RX_PARITY_EN.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [LANE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              frame_err_pulse,
`ifdef UART_RX_PARITY_EN
  output logic              parity_err_pulse,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]        sync;
  logic              rxs;
  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [LANE_W-1:0] shreg;
  logic              tick;
  logic              stop_sample;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  assign rxs         = sync[1];
  assign tick        = (cnt == '0);
  assign stop_sample = (state == STOP) && tick;
  assign busy        = (state != IDLE);
  assign byte_data   = shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], rxd};
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= HALF;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= FULL;
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= {rxs, shreg[LANE_W-1:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_bad <= (rxs != ^shreg);
            cnt     <= FULL;
            state   <= STOP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // Leave mid stop bit so a back-to-back start edge is caught on time.
          if (tick) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frame_err_pulse = stop_sample && !rxs;
`ifdef UART_RX_PARITY_EN
  assign byte_valid       = stop_sample && rxs && !par_bad;
  assign parity_err_pulse = (state == PARITY) && tick && (rxs != ^shreg);
`else
  assign byte_valid       = stop_sample && rxs;
`endif

endmodule

// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - UART receiver packing four little-endian bytes into 32-bit write strobes
// Define UART_RX_PARITY_EN for an even-parity bit after each data byte.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [31:0] wd,
  output logic        we,
  output logic        busy,
  output logic        frame_err,
  output logic        parity_err
);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_word_rx: CLKS_PER_BIT must be at least 4");
  end

  logic [LANE_W-1:0] byte_data;
  logic              byte_valid;
  logic              frame_err_pulse;
  logic [1:0]        lane;
`ifdef UART_RX_PARITY_EN
  logic              parity_err_pulse;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk             (clk),
    .rst             (rst),
    .rxd             (rxd),
    .byte_data       (byte_data),
    .byte_valid      (byte_valid),
    .frame_err_pulse (frame_err_pulse),
`ifdef UART_RX_PARITY_EN
    .parity_err_pulse(parity_err_pulse),
`endif
    .busy            (busy)
  );

  // Discarded bytes never reach here, so the lane only moves on good bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd        <= '0;
      we        <= 1'b0;
      lane      <= '0;
      frame_err <= 1'b0;
    end else begin
      we <= 1'b0;
      if (frame_err_pulse) begin
        frame_err <= 1'b1;
      end
      if (byte_valid) begin
        wd[lane*LANE_W +: LANE_W] <= byte_data;
        lane                      <= lane + 2'd1;
        if (lane == 2'd3) begin
          we <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (parity_err_pulse) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

- Serial receive front end for the program/data loader.
- Samples the UART line (8 data bits, 1 stop bit, LSB first, no flow control) and assembles four consecutive bytes, little-endian, into 32-bit words.
- Presents each completed word as a one-cycle write strobe that feeds the word buffer in front of the cache fill path.
- The consumer always accepts, so there is no backpressure.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division, 868 by default), clocks per bit period; must be ≥ 4 (elaboration-time assertion)

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge
- rst  in  1  synchronous, active-high reset
- rxd  in  1  asynchronous serial input, idle high
- wd  out  32  assembled word; first received byte is in [7:0], fourth byte in [31:24]
- we  out  1  one-cycle strobe; wd is valid in the same cycle
- busy  out  1  high while a byte frame is being received (any state other than IDLE)
- frame_err  out  1  sticky; set when a stop bit is sampled low; cleared only by rst
- parity_err  out  1  sticky parity error; tied 0 when parity is compiled out

## Operation
- Input synchronisation: rxd passes through a 2-flop synchroniser (reset to 1). All decisions use the synchronised value, rxs.
- Byte FSM states: IDLE, START, DATA, optional PARITY, STOP. A bit-period counter and a 3-bit bit index run alongside.
  - IDLE: rxs = 0 → START, with the counter loaded.
  - START: wait CLKS_PER_BIT/2 clocks, then sample. rxs = 1 is a false start → IDLE with no side effects. rxs = 0 → DATA, bit index 0.
  - DATA: every CLKS_PER_BIT clocks, shift the sampled bit in LSB first. After bit 7 → PARITY if compiled in, else STOP.
  - STOP: after CLKS_PER_BIT clocks, sample. rxs = 1 → byte accepted. rxs = 0 → frame_err ← 1 and the byte is discarded. Either way, return to IDLE in the same cycle, mid stop bit, so a new start edge is detected immediately.
- Word assembly:
  - A 2-bit lane index selects which wd byte an accepted byte is written into.
  - Lane 3 completes the word: we pulses and the lane returns to 0.
  - Discarded bytes do not advance the lane.
- wd holds its value between strobes. Partially filled lanes are visible on wd but are not valid.
- Reset values: wd = 0, we = 0, busy = 0, frame_err = 0, parity_err = 0, lane = 0, FSM = IDLE, synchroniser = 1.

## Timing
- Input latency: 2 clk from rxd to rxs.
- Data bits are sampled at (k + 1.5)·CLKS_PER_BIT clocks after the start edge seen on rxs, for k = 0..7.
- Byte acceptance happens on the stop-bit sample cycle S. we is registered high in cycle S+1 for exactly one cycle, with wd complete in S+1.
- Back-to-back frames with zero idle time are received without loss. The minimum spacing between we pulses is 4 byte frames.
- rst asserted mid-frame:
  - The partial byte and the partial word are dropped.
  - The next cycle shows reset values on every output.
  - The line is resynchronised from IDLE, so a frame already in progress is ignored until its bits happen to contain a falling edge. The host restarts transmission after reset.
- Simultaneous events: an error on the byte that would complete a word suppresses we, and the lane stays at 3.

## Configuration
- UART_RX_PARITY_EN defined: an even-parity bit follows bit 7 and is sampled in state PARITY. On mismatch, parity_err ← 1 (sticky), the byte is discarded, and the frame still proceeds through STOP.
- UART_RX_PARITY_EN undefined: the PARITY state and its logic are absent, the frame is 8N1, and parity_err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the FSM state enum rx_state_t (IDLE, START, DATA, PARITY, STOP)
  - a localparam function computing CLKS_PER_BIT
  - the byte-lane width constant
- Sub-module uart_rx_byte contains the synchroniser, the byte FSM and the bit counter. It outputs byte_valid, byte_data[7:0] and the error pulses.
- The top level performs lane packing, the strobe, and the sticky error flags.

## Test plan
- Send 0x78, 0x56, 0x34, 0x12 with 1-bit idle gaps → exactly one we, with wd = 0x12345678, in cycle S+1 after the 4th stop-bit sample.
- Eight bytes 0x01..0x08 back-to-back with no idle time → two we pulses, with wd = 0x04030201 then 0x08070605.
- Low glitch on rxd of CLKS_PER_BIT/4 clocks → returns to IDLE; no we; lane unchanged; errors remain 0.
- Second byte sent with stop bit 0, then three good bytes 0xAA, 0xBB, 0xCC → frame_err = 1; one we with wd = 0xCCBBAA followed by the first byte in [7:0]; lane alignment preserved.
- rst pulsed during DATA of the 3rd byte, then four fresh bytes 0x11, 0x22, 0x33, 0x44 → all outputs 0 in the cycle after reset; a single we with wd = 0x44332211.
- With UART_RX_PARITY_EN: byte 0x03 sent with parity bit 1 → parity_err = 1, byte dropped, no lane advance. Byte 0x03 with parity bit 0 → accepted.
